// File: rtl/cell_grabber_pkg.sv
// Shared definitions for the Sudoku cell grabber.
// Holds the cell geometry, the pixel-index width, the FSM state encoding and
// the pixel field helpers used by the threshold logic.
package cell_grabber_pkg;

    localparam int CELL_SZ  = 52;              // cell edge in pixels
    localparam int CELL_PIX = CELL_SZ * CELL_SZ; // 2704 pixels per cell
    localparam int GRID_N   = 9;               // cells per board edge
    localparam int IDX_W    = 12;              // enough for 0..2703

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Pixel word is {r[3:0], g[3:0], b[3:0]}.
    function automatic logic [3:0] pix_r(input logic [11:0] p);
        return p[11:8];
    endfunction

    function automatic logic [3:0] pix_g(input logic [11:0] p);
        return p[7:4];
    endfunction

    function automatic logic [3:0] pix_b(input logic [11:0] p);
        return p[3:0];
    endfunction

    // Six bits hold the worst case 45, so the sum never wraps.
    function automatic logic [5:0] pix_sum(input logic [11:0] p);
        return {2'b00, pix_r(p)} + {2'b00, pix_g(p)} + {2'b00, pix_b(p)};
    endfunction

endpackage

// File: rtl/cell_grabber_addr_gen.sv
// Raster address generator for one cell.
// On load it computes the frame-buffer address of the cell's top-left pixel
// and issues pixel 0; each step advances one pixel row-major, jumping to the
// next frame line after column 51.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         compute base from row/col and issue pixel 0
//   step         issue the next pixel
//   row, col     cell coordinates (already range-checked by the caller)
//   mem_addr     registered frame-buffer address
//   pix_idx      index (0..2703) of the pixel whose address is on mem_addr
//   last_issue   the next step issues the final pixel (index 2703)
module cell_grabber_addr_gen
    import cell_grabber_pkg::*;
#(
    parameter int FRAME_W    = 320,
    parameter int ADDR_W     = 17,
    parameter int GRID_X0    = 28,
    parameter int GRID_Y0    = 4,
    parameter int CELL_PITCH = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [3:0]        row,
    input  logic [3:0]        col,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              last_issue
);

    logic [ADDR_W-1:0] addr_q, addr_d, base;
    logic [5:0]        col_q, col_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    always_comb begin
        base   = ADDR_W'((GRID_Y0 + int'(row) * CELL_PITCH) * FRAME_W
                         + GRID_X0 + int'(col) * CELL_PITCH);
        addr_d = addr_q;
        col_d  = col_q;
        idx_d  = idx_q;
        if (load) begin
            addr_d = base;
            col_d  = '0;
            idx_d  = '0;
        end else if (step) begin
            idx_d = idx_q + IDX_W'(1);
            if (col_q == 6'(CELL_SZ - 1)) begin
                // end of a cell row: skip the rest of the frame line
                addr_d = addr_q + ADDR_W'(FRAME_W - CELL_SZ + 1);
                col_d  = '0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
                col_d  = col_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            col_q  <= '0;
            idx_q  <= '0;
        end else begin
            addr_q <= addr_d;
            col_q  <= col_d;
            idx_q  <= idx_d;
        end
    end

    assign mem_addr   = addr_q;
    assign pix_idx    = idx_q;
    assign last_issue = (idx_q == IDX_W'(CELL_PIX - 2));

endmodule

// File: rtl/cell_grabber.sv
// Extracts one 52x52 Sudoku cell from the frame buffer and builds a
// thresholded bitmap (1 = ink) for the scaler.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               capture request, accepted only when idle
//   cell_row, cell_col  cell coordinates latched on accepted start
//   mem_addr            frame-buffer read address (registered)
//   mem_data            pixel {r,g,b}, valid RD_LAT clocks after its address
//   img                 bitmap, bit r*52+c = cell pixel (r,c)
//   busy                capture in progress
//   done                one-cycle pulse when img is complete
//   invalid             raised with done when row or col is out of range
module cell_grabber
    import cell_grabber_pkg::*;
#(
    parameter int FRAME_W    = 320,
    parameter int ADDR_W     = 17,
    parameter int GRID_X0    = 28,
    parameter int GRID_Y0    = 4,
    parameter int CELL_PITCH = 26,
    parameter int RD_LAT     = 1,
    parameter int THRESH     = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3:0]          cell_row,
    input  logic [3:0]          cell_col,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [11:0]         mem_data,
    output logic [CELL_PIX-1:0] img,
    output logic                busy,
    output logic                done,
    output logic                invalid
);

    state_t              state_q, state_d;
    logic [3:0]          row_q, row_d, col_q, col_d;
    logic                busy_q, busy_d, done_q, done_d, invalid_q, invalid_d;
    logic [CELL_PIX-1:0] img_q, img_d;

    // Stage 0 of the valid pipe travels with mem_addr; stage RD_LAT lines
    // up with mem_data.  The index for stage 0 lives in the address generator.
    logic [RD_LAT:0]             vld_pipe_q, vld_pipe_d;
    logic [RD_LAT:1][IDX_W-1:0]  idx_pipe_q, idx_pipe_d;

    logic             ag_load, ag_step, issue, last_issue, drain_pending, ink;
    logic [IDX_W-1:0] pix_idx;

    cell_grabber_addr_gen #(
        .FRAME_W    (FRAME_W),
        .ADDR_W     (ADDR_W),
        .GRID_X0    (GRID_X0),
        .GRID_Y0    (GRID_Y0),
        .CELL_PITCH (CELL_PITCH)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ag_load),
        .step       (ag_step),
        .row        (row_q),
        .col        (col_q),
        .mem_addr   (mem_addr),
        .pix_idx    (pix_idx),
        .last_issue (last_issue)
    );

    assign ink = (pix_sum(mem_data) < 6'(THRESH));

    always_comb begin
        vld_pipe_d    = {vld_pipe_q[RD_LAT-1:0], issue};
        idx_pipe_d    = '0;
        idx_pipe_d[1] = pix_idx;
        for (int i = 2; i <= RD_LAT; i++) begin
            idx_pipe_d[i] = idx_pipe_q[i-1];
        end
        // Leave DRAIN once only the final stage may still hold a pixel:
        // that pixel is captured on the same edge that enters DONE's exit.
        drain_pending = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            drain_pending = drain_pending | vld_pipe_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        invalid_d = invalid_q;
        img_d     = img_q;
        ag_load   = 1'b0;
        ag_step   = 1'b0;
        issue     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d     = cell_row;
                    col_d     = cell_col;
                    img_d     = '0;
                    busy_d    = 1'b1;
                    invalid_d = 1'b0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (row_q >= 4'(GRID_N) || col_q >= 4'(GRID_N)) begin
                    invalid_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    ag_load = 1'b1;
                    issue   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ag_step = 1'b1;
                issue   = 1'b1;
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drain_pending) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (vld_pipe_q[RD_LAT]) begin
            img_d[idx_pipe_q[RD_LAT]] = ink;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            invalid_q  <= 1'b0;
            img_q      <= '0;
            vld_pipe_q <= '0;
            idx_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            invalid_q  <= invalid_d;
            img_q      <= img_d;
            vld_pipe_q <= vld_pipe_d;
            idx_pipe_q <= idx_pipe_d;
        end
    end

    assign img     = img_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_cell_grabber.sv
// Directed bench for cell_grabber: two instances (read latency 1 and 3)
// share stimulus, each fed by its own frame-buffer model.
module tb_cell_grabber;

    localparam int NPIX = 2704;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        cell_row = '0;
    logic [3:0]        cell_col = '0;
    logic [16:0]       mem_addr1, mem_addr3;
    logic [11:0]       mem_data1, mem_data3;
    logic [NPIX-1:0]   img1, img3;
    logic              busy1, busy3, done1, done3, invalid1, invalid3;

    int n_cmp = 0;
    int n_bad = 0;
    int frame_mode = 0;   // 0 checker, 1 black, 2 white, 3 threshold edge

    always #5 clk = ~clk;

    cell_grabber #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .cell_row(cell_row),
        .cell_col(cell_col), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .img(img1), .busy(busy1), .done(done1), .invalid(invalid1)
    );

    cell_grabber #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .cell_row(cell_row),
        .cell_col(cell_col), .mem_addr(mem_addr3), .mem_data(mem_data3),
        .img(img3), .busy(busy3), .done(done3), .invalid(invalid3)
    );

    function automatic logic [11:0] pix(input int a);
        int x, y;
        x = a % 320;
        y = a / 320;
        case (frame_mode)
            0:       return ((x + y) % 2 == 1) ? 12'h000 : 12'hFFF;
            1:       return 12'h000;
            2:       return 12'hFFF;
            default: return (x % 2 == 0) ? 12'h887 : 12'h888; // sums 23 / 24
        endcase
    endfunction

    // Frame-buffer models: RD_LAT register stages after the address.
    logic [11:0] m1_q, m3a_q, m3b_q, m3c_q;
    always @(posedge clk) begin
        m1_q  <= pix(int'(mem_addr1));
        m3a_q <= pix(int'(mem_addr3));
        m3b_q <= m3a_q;
        m3c_q <= m3b_q;
    end
    assign mem_data1 = m1_q;
    assign mem_data3 = m3c_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hand-derived ink for cell (r,c) pixel k under the current frame.
    function automatic bit exp_ink(input int r, input int c, input int k);
        int x, y;
        x = 28 + c * 26 + k % 52;
        y = 4 + r * 26 + k / 52;
        case (frame_mode)
            0:       return ((x + y) % 2) == 1;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return (x % 2) == 0;
        endcase
    endfunction

    function automatic int img_errs(input logic [NPIX-1:0] im, input int r, input int c);
        int e = 0;
        for (int k = 0; k < NPIX; k++) if (im[k] !== exp_ink(r, c, k)) e++;
        return e;
    endfunction

    // results of the latest run
    int done1_edge, done3_edge, n_done1, addr_moves, busy3_err;
    int first_addr, last_addr;
    logic inval_at_done, rst_busy, rst_img_nz;

    task automatic run(input int r, input int c, input int pulse_at, input int rst_at);
        logic [16:0] prev;
        done1_edge = -1; done3_edge = -1; n_done1 = 0; addr_moves = 0;
        busy3_err = 0; first_addr = -1; last_addr = -1; inval_at_done = 1'b0;
        @(negedge clk);
        start = 1'b1; cell_row = 4'(r); cell_col = 4'(c);
        @(posedge clk); #1;              // edge 0
        prev = mem_addr1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 2715; e++) begin
            @(posedge clk); #1;
            if (done1) begin
                n_done1++;
                if (done1_edge < 0) done1_edge = e;
                inval_at_done = invalid1;
            end
            if (done3 && done3_edge < 0) done3_edge = e;
            if (busy3 !== (e <= 2707)) busy3_err++;
            if (e == 1) first_addr = int'(mem_addr1);
            if (e == 2704) last_addr = int'(mem_addr1);
            if (mem_addr1 != prev) addr_moves++;
            prev = mem_addr1;
            if (e == pulse_at - 1) begin
                start = 1'b1; cell_row = 4'd5; cell_col = 4'd5;
            end
            if (e == pulse_at) start = 1'b0;
            if (e == rst_at) begin
                rst_n = 1'b0;
                #1;
                rst_busy   = busy1;
                rst_img_nz = |img1;
                break;
            end
        end
        if (rst_n == 1'b0) begin
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                if (done1) n_done1++;
            end
        end
        $display("run cell(%0d,%0d) mode %0d: done1@%0d done3@%0d dones=%0d first=%0d last=%0d inv=%0d",
                 r, c, frame_mode, done1_edge, done3_edge, n_done1, first_addr, last_addr, inval_at_done);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_img",     32'(|img1), 0);
        check("rst_busy",    32'(busy1), 0);
        check("rst_done",    32'(done1), 0);
        check("rst_invalid", 32'(invalid1), 0);
        check("rst_addr",    32'(mem_addr1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // checkerboard, cell (0,0)
        frame_mode = 0;
        run(0, 0, -10, -10);
        check("chk_done_edge", 32'(done1_edge), 2706);
        check("chk_first",     32'(first_addr), 1308);
        check("chk_img_errs",  32'(img_errs(img1, 0, 0)), 0);
        check("chk_ndone",     32'(n_done1), 1);
        check("chk_invalid",   32'(inval_at_done), 0);
        check("chk3_img_errs", 32'(img_errs(img3, 0, 0)), 0);

        // black frame, cell (8,8)
        frame_mode = 1;
        run(8, 8, -10, -10);
        check("blk_first",  32'(first_addr), 68076);
        check("blk_last",   32'(last_addr), 84447);
        check("blk_ones",   32'($countones(img1)), 2704);
        check("blk_done",   32'(done1_edge), 2706);

        // white frame, latency 3 timing
        frame_mode = 2;
        run(2, 3, -10, -10);
        check("wht3_done",   32'(done3_edge), 2708);
        check("wht3_busy",   32'(busy3_err), 0);
        check("wht3_img",    32'(|img3), 0);
        check("wht1_img",    32'(|img1), 0);

        // out-of-range row
        frame_mode = 1;
        run(9, 0, -10, -10);
        check("inv_done_edge", 32'(done1_edge), 2);
        check("inv_flag",      32'(inval_at_done), 1);
        check("inv_img",       32'(|img1), 0);
        check("inv_no_reads",  32'(addr_moves), 0);
        check("inv_hold",      32'(invalid1), 1);
        check("inv3_done",     32'(done3_edge), 2);

        // second start at edge 100 is ignored
        frame_mode = 0;
        run(0, 0, 100, -10);
        check("rep_ndone",   32'(n_done1), 1);
        check("rep_done",    32'(done1_edge), 2706);
        check("rep_img",     32'(img_errs(img1, 0, 0)), 0);
        check("rep_inv_clr", 32'(invalid1), 0);

        // reset at edge 1000, then a fresh capture
        run(1, 2, -10, 1000);
        check("rst_mid_busy", 32'(rst_busy), 0);
        check("rst_mid_img",  32'(rst_img_nz), 0);
        check("rst_mid_done", 32'(n_done1), 0);
        run(1, 2, -10, -10);
        check("post_rst_done", 32'(done1_edge), 2706);
        check("post_rst_img",  32'(img_errs(img1, 1, 2)), 0);

        // threshold edge: sum 23 is ink, sum 24 is not
        frame_mode = 3;
        run(0, 0, -10, -10);
        check("thr_23", 32'(img1[0]), 1);
        check("thr_24", 32'(img1[1]), 0);
        check("thr_img", 32'(img_errs(img1, 0, 0)), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
